mem_responder: RTL

- Unified instruction/data memory responder that services the multi-cycle processor's memory requests (instruction fetch and load/store).
- It is the slave end of the memory interface driven by the processor control path.
- It accepts one request at a time, inserts a configurable number of wait states, and then completes the access with a single-cycle ready pulse.
- The memory array is a word-addressed register file inside the block.

---
 rtl/mem_responder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Unified instruction/data memory slave with programmable wait
//               states and a single-cycle ready pulse on completion.
// Revision    : 1.0  initial release
// ============================================================================

module mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy
);

    localparam int         C_DEPTH     = 2**ADDR_W;
    localparam bit         C_NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0] C_WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   w_wdata_nxt;
    logic                r_we;
    logic                w_we_nxt;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   w_rdata_nxt;
    logic                r_ready;
    logic                w_ready_nxt;
    logic                r_busy;
    logic                w_busy_nxt;

    // Memory access performed on the edge that enters RESP
    logic                w_acc_fire;
    logic                w_acc_we;
    logic [ADDR_W-1:0]   w_acc_addr;
    logic [DATA_W-1:0]   w_acc_wdata;
    logic                w_mem_we;

    logic [DATA_W-1:0]   r_mem [C_DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_we    <= w_we_nxt;
            r_rdata <= w_rdata_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_we_nxt    = r_we;
        w_ready_nxt = 1'b0;
        w_busy_nxt  = r_busy;
        w_acc_fire  = 1'b0;
        w_acc_we    = r_we;
        w_acc_addr  = r_addr;
        w_acc_wdata = r_wdata;

        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (req) begin
                    w_addr_nxt  = addr;
                    w_wdata_nxt = wdata;
                    w_we_nxt    = we;
                    w_busy_nxt  = 1'b1;
                    if (C_NO_WAIT) begin
                        // Zero wait states: capture and access share one edge,
                        // so the memory sees the live request fields.
                        w_state_nxt = S_RESP;
                        w_ready_nxt = 1'b1;
                        w_acc_fire  = 1'b1;
                        w_acc_we    = we;
                        w_acc_addr  = addr;
                        w_acc_wdata = wdata;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = C_WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                w_busy_nxt = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                    w_ready_nxt = 1'b1;
                    w_acc_fire  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Gated by rst so no write can land while reset is held.
    assign w_mem_we    = w_acc_fire & w_acc_we & rst;
    assign w_rdata_nxt = (w_acc_fire && !w_acc_we) ? r_mem[w_acc_addr] : r_rdata;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_acc_addr] <= w_acc_wdata;
        end
    end

    assign rdata = r_rdata;
    assign ready = r_ready;
    assign busy  = r_busy;

endmodule

`default_nettype wire
